// File: rtl/sisc_pkg.sv
// Shared SISC definitions: default address width, the NOP encoding and the
// instruction-fetch FSM state type.
package sisc_pkg;

  localparam int SISC_ADDR_W = 16;
  localparam logic [31:0] SISC_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/sisc_ifetch_buf.sv
// Small shift-style FIFO of {address, instruction} pairs; entry 0 is the head.
// Presents NOP on the data output while empty.
module sisc_ifetch_buf
  import sisc_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = SISC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [31:0]       push_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [31:0]       head_data,
  output logic              empty,
  output logic              full,
  output logic              space_next
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]             count_reg, count_next;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_reg, addr_next;
  logic [DEPTH-1:0][31:0]       data_reg, data_next;
  logic                         pop_eff, push_eff;
  logic [CNT_W-1:0]             base;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  // Slot the pushed entry lands in once the pop (if any) has shifted the queue.
  assign base     = count_reg - CNT_W'(pop_eff);

  assign count_next = flush ? '0 : base + CNT_W'(push_eff);
  assign space_next = (count_next < CNT_W'(DEPTH));

  genvar gi;
  for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_entry
    if (gi + 1 < DEPTH) begin : g_shift
      assign addr_next[gi] = (push_eff && base == CNT_W'(gi)) ? push_addr :
                             pop_eff ? addr_reg[gi+1] : addr_reg[gi];
      assign data_next[gi] = (push_eff && base == CNT_W'(gi)) ? push_data :
                             pop_eff ? data_reg[gi+1] : data_reg[gi];
    end else begin : g_last
      assign addr_next[gi] = (push_eff && base == CNT_W'(gi)) ? push_addr : addr_reg[gi];
      assign data_next[gi] = (push_eff && base == CNT_W'(gi)) ? push_data : data_reg[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      count_reg <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      count_reg <= count_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  assign head_addr = addr_reg[0];
  assign head_data = empty ? SISC_NOP : data_reg[0];

endmodule

// File: rtl/sisc_ifetch.sv
// SISC instruction fetch unit: single-outstanding request/ack fetch into a small
// buffer, with branch redirect and squash. Define SISC_IFETCH_PREFETCH_EN for a
// 2-entry buffer that overlaps fetch with execution (default: 1 entry).
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int                ADDR_W   = SISC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              ir_take,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr
);

`ifdef SISC_IFETCH_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  ifetch_state_t     state_reg, state_next;
  logic              mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic              squash_reg, squash_next;
  logic [ADDR_W-1:0] squash_addr_reg, squash_addr_next;

  logic xfer, buf_push, buf_pop, buf_empty, buf_full, buf_space_next;

  assign xfer     = mem_req_reg && mem_ack;
  assign buf_push = xfer && !squash_reg && !br_taken;
  assign buf_pop  = ir_take && !br_taken;

  sisc_ifetch_buf #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk        (clk),
    .rst_f      (rst_f),
    .push       (buf_push),
    .pop        (buf_pop),
    .flush      (br_taken),
    .push_addr  (mem_addr_reg),
    .push_data  (mem_rdata),
    .head_addr  (pc_out),
    .head_data  (ir),
    .empty      (buf_empty),
    .full       (buf_full),
    .space_next (buf_space_next)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg       <= IDLE;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= RESET_PC;
      squash_reg      <= 1'b0;
      squash_addr_reg <= '0;
    end else begin
      state_reg       <= state_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
      squash_reg      <= squash_next;
      squash_addr_reg <= squash_addr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    mem_addr_next    = mem_addr_reg;
    squash_next      = squash_reg;
    squash_addr_next = squash_addr_reg;
    case (state_reg)
      IDLE: begin
        state_next = REQ;
        if (br_taken) mem_addr_next = br_addr;
      end
      REQ: begin
        if (mem_ack) begin
          // A pending squash redirects unless a newer branch arrives on this edge.
          squash_next   = 1'b0;
          mem_addr_next = br_taken   ? br_addr :
                          squash_reg ? squash_addr_reg :
                                       mem_addr_reg + ADDR_W'(1);
          state_next    = buf_space_next ? REQ : WAIT;
        end else if (br_taken) begin
          squash_next      = 1'b1;
          squash_addr_next = br_addr;
        end
      end
      WAIT: begin
        if (br_taken) mem_addr_next = br_addr;
        if (br_taken || ir_take || !buf_full) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
    mem_req_next = (state_next == REQ);
  end

  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;
  assign ir_valid = !buf_empty;

endmodule
